mp_addsub_serial: RTL and testbench

- Parametrised multi-cycle, limb-serial multi-precision adder/subtractor with an optional right-shift by one.
- Successor to the single-cycle carry-select adder in the Montgomery datapath. Width and limb size are generic, so timing closes at any operand width.
- Operands are latched on start. One LIMB-bit slice is processed per cycle with a registered carry chain.
- A one-cycle done pulse is issued, and the result is held until the next accepted start.

---
 rtl/mp_arith_pkg.sv | 22 ++
 rtl/mp_limb_add.sv | 14 +
 rtl/mp_addsub_serial.sv | 112 +++++++++++
 tb/tb_mp_addsub_serial.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_arith_pkg.sv
// Shared encodings and sizing helpers for the limb-serial multi-precision arithmetic blocks.
package mp_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nlimb(input int width, input int limb);
      return (width + limb - 1) / limb;
   endfunction

   // Never returns 0 so a single-limb configuration still gets a 1-bit counter.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mp_limb_add.sv
// Combinational W-bit adder with carry-in/carry-out; one limb of the serial chain.
module mp_limb_add #(
   parameter int W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_serial.sv
// Limb-serial multi-precision a+b / a-b with optional logical right shift by one.
module mp_addsub_serial
   import mp_arith_pkg::*;
#(
   parameter int WIDTH = 514,
   parameter int LIMB  = 128
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             subtract,
   input  logic             shift,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam int NLIMB  = nlimb(WIDTH, LIMB);
   localparam int CW     = clog2(NLIMB);
   localparam int PW     = NLIMB * LIMB;
   localparam int LO     = (NLIMB - 1) * LIMB;
   localparam int LAST_W = WIDTH - LO;

   state_t          state, state_nx;
   logic [PW-1:0]   a_q, b_q;
   logic            c_q, sub_q, shf_q;
   logic [CW-1:0]   cnt;
   logic [LIMB-1:0] la, lb, sum;
   logic            cout, c_fin, last, accept;
   logic [WIDTH:0]  f;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (cnt == CW'(NLIMB - 1));
   assign busy   = (state == CALC);
   assign done   = (state == DONE);

   always_comb begin
      la = '0;
      lb = '0;
      for (int k = 0; k < NLIMB; k++) begin
         if (cnt == CW'(k)) begin
            la = a_q[k*LIMB +: LIMB];
            lb = b_q[k*LIMB +: LIMB];
         end
      end
   end

   mp_limb_add #(.W(LIMB)) u_add (
      .a    (la),
      .b    (lb),
      .cin  (c_q),
      .sum  (sum),
      .cout (cout)
   );

   // Operands are zero-padded above WIDTH, so the narrow last limb's carry lands on sum[LAST_W].
   assign c_fin = (LAST_W == LIMB) ? cout : sum[LAST_W % LIMB];

   always_comb begin
      f = result;
      for (int i = 0; i < LAST_W; i++) f[LO+i] = sum[i];
      f[WIDTH] = c_fin ^ sub_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (last)  state_nx = DONE;
         DONE:    state_nx = start ? CALC : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         sub_q  <= 1'b0;
         shf_q  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         carry  <= 1'b0;
      end else if (accept) begin
         a_q   <= PW'(in_a);
         b_q   <= PW'(in_b ^ {WIDTH{subtract}});
         c_q   <= subtract;
         sub_q <= subtract;
         shf_q <= shift;
         cnt   <= '0;
      end else if (state == CALC) begin
         c_q <= cout;
         cnt <= cnt + 1'b1;
         for (int k = 0; k < NLIMB - 1; k++)
            if (cnt == CW'(k)) result[k*LIMB +: LIMB] <= sum;
         if (last) begin
            result <= shf_q ? {1'b0, f[WIDTH:1]} : f;
            carry  <= c_fin;
         end
      end
   end

endmodule

// File: tb/tb_mp_addsub_serial.sv
// Scoreboard bench for mp_addsub_serial: directed vectors plus a random batch against an arithmetic model.
module tb_mp_addsub_serial;

   localparam int W  = 514;
   localparam int NL = 5;

   logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, subtract = 1'b0, shift = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic [W:0]   result;
   logic         carry, busy, done;

   mp_addsub_serial #(.WIDTH(W), .LIMB(128)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .subtract (subtract),
      .shift    (shift),
      .in_a     (in_a),
      .in_b     (in_b),
      .result   (result),
      .carry    (carry),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W:0]  res;
      logic        c;
      int unsigned at;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_err = 0;

   task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every done cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("carry", (W+1)'(carry), (W+1)'(e.c));
            check("done_cycle", (W+1)'(cyc), (W+1)'(e.at));
         end
      end
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic shf);
      exp_t       e;
      logic [W:0] f;
      f     = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      e.c   = sub ? ~f[W] : f[W];
      e.res = shf ? (f >> 1) : f;
      e.at  = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return W'(t[31:0]);
         default: return t[W-1:0];
      endcase
   endfunction

   // Called at a negedge; the next posedge accepts, done shows NL+1 negedges later.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic shf, input logic [W:0] res, input logic c);
      exp_t e;
      in_a = a; in_b = b; subtract = sub; shift = shf; start = 1'b1;
      e.res = res; e.c = c; e.at = cyc + NL + 1;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
      end
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic shf, input logic [W:0] res, input logic c);
      @(negedge clk);
      issue(a, b, sub, shf, res, c);
      @(negedge clk);
      start = 1'b0;
      wait_done(tag);
   endtask

   initial begin
      logic [W-1:0] ones;
      ones = '1;

      repeat (3) @(negedge clk);
      check("rst_result", result, '0);
      check("rst_carry", (W+1)'(carry), '0);
      check("rst_busy", (W+1)'(busy), '0);
      check("rst_done", (W+1)'(done), '0);
      resetn = 1'b1;

      run("add_max_plus1", ones, W'(1), 1'b0, 1'b0, {1'b1, {W{1'b0}}}, 1'b1);
      run("sub_5_7", W'(5), W'(7), 1'b1, 1'b0, {{W{1'b1}}, 1'b0}, 1'b0);
      run("sub_7_5", W'(7), W'(5), 1'b1, 1'b0, (W+1)'(2), 1'b1);
      run("add_shift", W'(3), W'(2), 1'b0, 1'b1, (W+1)'(2), 1'b0);
      run("sub_shift", W'(10), W'(4), 1'b1, 1'b1, (W+1)'(3), 1'b1);
      run("add_max_shift", ones, ones, 1'b0, 1'b1, {1'b0, ones}, 1'b1);

      // Back-to-back: start stays high through CALC and into DONE.
      @(negedge clk);
      issue(W'(7), W'(5), 1'b1, 1'b0, (W+1)'(2), 1'b1);
      @(negedge clk);
      wait_done("b2b_first");
      issue(W'(1), W'(1), 1'b0, 1'b0, (W+1)'(2), 1'b0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", (W+1)'(busy), (W+1)'(1));
      wait_done("b2b_second");

      // A start pulse mid-CALC must neither restart nor add a done.
      @(negedge clk);
      issue(W'(3), W'(2), 1'b0, 1'b0, (W+1)'(5), 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in_a = ones; in_b = W'(1); subtract = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("calc_pulse");
      repeat (3) @(negedge clk);
      check("held_result", result, (W+1)'(5));
      check("held_carry", (W+1)'(carry), '0);
      check("held_done", (W+1)'(done), '0);

      // Reset at the third CALC edge discards the operation.
      @(negedge clk);
      in_a = ones; in_b = ones; subtract = 1'b0; shift = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("calc_busy", (W+1)'(busy), (W+1)'(1));
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check("midrst_result", result, '0);
      check("midrst_carry", (W+1)'(carry), '0);
      check("midrst_busy", (W+1)'(busy), '0);
      check("midrst_done", (W+1)'(done), '0);
      resetn = 1'b1;
      run("after_reset", W'(100), W'(23), 1'b0, 1'b0, (W+1)'(123), 1'b0);

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] a, b;
         logic         sub, shf;
         exp_t         e;
         a = rnd(); b = rnd();
         sub = 1'($urandom_range(0, 1));
         shf = 1'($urandom_range(0, 1));
         e = model(a, b, sub, shf);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         issue(a, b, sub, shf, e.res, e.c);
         @(negedge clk);
         start = 1'b0;
         wait_done("random");
      end

      repeat (10) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
